const_encoder: RTL and testbench
================================

// Module: const_encoder
// PURPOSE
//   Inverse of the decode-side immediate extenders: turns a 16-bit constant into the
//   shortest LI / SLL / ADDIU sequence that rebuilds it in register rd.
//   Once extended, that sequence reproduces the value exactly (zero-ext 8-bit LI imm, sign-ext 8-bit ADDIU imm).
//   Sits between the boot/monitor loader and the instruction-memory write port.
//   Streams one 16-bit instruction per accepted output beat.
// PARAMETERS
//   ALLOW_SHORT  1  1: use 1/2-instruction forms when possible; 0: always emit 3 instructions
// PORTS
//   clk        in   1   system clock, rising edge
//   rst        in   1   asynchronous, active-high reset
//   in_valid   in   1   request valid
//   in_ready   out  1   block can accept a request (high only in IDLE)
//   in_value   in   16  constant to materialise (`DATA_BUS)
//   in_rd      in   3   destination register index
//   out_valid  out  1   out_inst is valid
//   out_ready  in   1   consumer accepts out_inst this cycle
//   out_inst   out  16  encoded instruction (`INST_BUS)
//   out_last   out  1   out_inst is the final instruction of the sequence
//   out_count  out  2   total instruction count of current sequence (1..3), valid with out_valid
// BEHAVIOUR
//   Reset (async, any state): state=IDLE; out_valid=0, out_inst=0, out_last=0, out_count=0, in_ready=1.
//   Encodings (rd repeated where ry needed):
//     LI    rd,imm8 = {5'b01101, rd, imm8}
//     SLL   rd,rd,8 = {5'b00110, rd, rd, 3'b000, 2'b00}   (sa field 0 = shift 8)
//     ADDIU rd,imm8 = {5'b01001, rd, imm8}
//   On capture, H=in_value[15:8], L=in_value[7:0], Hadj=(H + L[7]) mod 256 (8-bit wrap intended).
//   Sequence choice, fixed at capture:
//     ALLOW_SHORT=1 and H==0      -> LI rd,L                               (count 1)
//     ALLOW_SHORT=1 and L==0      -> LI rd,H ; SLL                          (count 2)
//     otherwise                   -> LI rd,Hadj ; SLL ; ADDIU rd,L          (count 3)
//     A value that meets both short forms (0x0000) takes the single-LI form: LI rd,0x00.
//   FSM states: IDLE, EMIT_LI, EMIT_SLL, EMIT_ADDIU.
//     IDLE:   in_ready=1; in_valid -> capture value/rd, go EMIT_LI.
//     EMIT_x: out_valid=1; out_valid&&out_ready -> next state in the chosen sequence.
//             After the last instruction of the sequence, return to IDLE.
//   Outputs are registered. The first instruction appears on the cycle after capture (latency 1).
//   Back-to-back beats are 1 per cycle while out_ready=1.
//   Back-to-back requests: 1 IDLE bubble cycle between sequences. IDLE does not pass through combinationally.
//   Backpressure: while out_valid&&!out_ready, out_inst/out_last/out_count hold stable.
//   in_ready=0 in all EMIT states. in_value/in_rd are ignored outside IDLE.
//   out_last=1 only on the final beat. out_count is constant for the whole sequence.
//   Reset asserted mid-sequence aborts it. No partial sequence resumes after reset.
// TESTING
//   1 in_value=0x0042, rd=3 -> one beat 0x6B42, out_last=1, out_count=1
//   2 in_value=0x1200, rd=1 -> 0x6912, 0x3120(last); out_count=2
//   3 in_value=0x12F0, rd=2 -> 0x6A13, 0x3240, 0x4AF0(last); Hadj=0x13 because L[7]=1
//   4 in_value=0xFF80, rd=0 -> 0x6800, 0x3000, 0x4880; Hadj wraps 0xFF+1=0x00
//     Also repeat test 1 with ALLOW_SHORT=0 -> 0x6B00, 0x3360, 0x4B42
//   5 test 3 with out_ready=0 for 3 cycles on the SLL beat -> 0x3240 held stable, in_ready=0,
//     then 0x4AF0 follows on the next cycle
//   6 rst pulsed during EMIT_SLL -> out_valid=0 immediately, in_ready=1
//     Next request 0x0042 rd=3 -> clean 0x6B42

Source files
------------

// File: rtl/const_encoder_if.sv
// Request/instruction-stream bundle for const_encoder.
//   Request side : in_valid, in_ready, in_value[15:0], in_rd[2:0]
//   Output side  : out_valid, out_ready, out_inst[15:0], out_last, out_count[1:0]
// The slave modport is the encoder's view. The master modport is the view of
// whoever issues requests and consumes the instruction stream.
interface const_encoder_if;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_value;
  logic [2:0]  in_rd;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_inst;
  logic        out_last;
  logic [1:0]  out_count;

  modport slave (
    input  in_valid, in_value, in_rd, out_ready,
    output in_ready, out_valid, out_inst, out_last, out_count
  );

  modport master (
    output in_valid, in_value, in_rd, out_ready,
    input  in_ready, out_valid, out_inst, out_last, out_count
  );
endinterface

// File: rtl/const_encoder.sv
// const_encoder: turns a 16-bit constant into the shortest LI / SLL / ADDIU
// sequence that rebuilds it in register rd. One instruction is streamed per
// accepted output beat.
// Ports:
//   clk  - system clock, rising edge
//   rst  - asynchronous, active-high reset
//   bus  - const_encoder_if.slave (request in, instruction stream out)
// Parameter:
//   ALLOW_SHORT - 1: use the 1- and 2-instruction forms when they fit;
//                 0: always emit the 3-instruction form.
module const_encoder #(
  parameter bit ALLOW_SHORT = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  const_encoder_if.slave     bus
);

  typedef enum logic [1:0] {
    IDLE,
    EMIT_LI,
    EMIT_SLL,
    EMIT_ADDIU
  } state_t;

  state_t      state;
  logic [2:0]  rd_q;
  logic [7:0]  low_q;

  logic [7:0]  hi_byte;
  logic [7:0]  lo_byte;
  logic [7:0]  hi_adj;
  logic [7:0]  li_imm;
  logic [1:0]  seq_count;

  function automatic logic [15:0] enc_li(input logic [2:0] rd, input logic [7:0] imm);
    return {5'b01101, rd, imm};
  endfunction

  // A zero sa field means "shift by 8", so this rebuilds H in the top byte.
  function automatic logic [15:0] enc_sll(input logic [2:0] rd);
    return {5'b00110, rd, rd, 3'b000, 2'b00};
  endfunction

  function automatic logic [15:0] enc_addiu(input logic [2:0] rd, input logic [7:0] imm);
    return {5'b01001, rd, imm};
  endfunction

  // Sequence selection from the incoming request. ADDIU sign-extends its
  // immediate, so when L[7] is set the high byte is pre-incremented to cancel
  // the borrow; the 8-bit wrap of 0xFF+1 is intended.
  always_comb begin
    hi_byte   = bus.in_value[15:8];
    lo_byte   = bus.in_value[7:0];
    hi_adj    = hi_byte + {7'b0000000, lo_byte[7]};
    seq_count = 2'd3;
    li_imm    = hi_adj;
    if (ALLOW_SHORT && (hi_byte == 8'h00)) begin
      seq_count = 2'd1;
      li_imm    = lo_byte;
    end else if (ALLOW_SHORT && (lo_byte == 8'h00)) begin
      seq_count = 2'd2;
      li_imm    = hi_byte;
    end
  end

  // Sequencer with registered outputs. The LI word is built at capture time so
  // it is presented on the following cycle; every later word is loaded as the
  // previous one is accepted, which keeps the outputs stable under backpressure.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      rd_q          <= 3'd0;
      low_q         <= 8'h00;
      bus.in_ready  <= 1'b1;
      bus.out_valid <= 1'b0;
      bus.out_inst  <= 16'h0000;
      bus.out_last  <= 1'b0;
      bus.out_count <= 2'd0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            rd_q          <= bus.in_rd;
            low_q         <= lo_byte;
            bus.in_ready  <= 1'b0;
            bus.out_valid <= 1'b1;
            bus.out_inst  <= enc_li(bus.in_rd, li_imm);
            bus.out_last  <= (seq_count == 2'd1);
            bus.out_count <= seq_count;
            state         <= EMIT_LI;
          end
        end
        EMIT_LI: begin
          if (bus.out_ready) begin
            if (bus.out_count == 2'd1) begin
              bus.in_ready  <= 1'b1;
              bus.out_valid <= 1'b0;
              bus.out_inst  <= 16'h0000;
              bus.out_last  <= 1'b0;
              bus.out_count <= 2'd0;
              state         <= IDLE;
            end else begin
              bus.out_inst <= enc_sll(rd_q);
              bus.out_last <= (bus.out_count == 2'd2);
              state        <= EMIT_SLL;
            end
          end
        end
        EMIT_SLL: begin
          if (bus.out_ready) begin
            if (bus.out_count == 2'd2) begin
              bus.in_ready  <= 1'b1;
              bus.out_valid <= 1'b0;
              bus.out_inst  <= 16'h0000;
              bus.out_last  <= 1'b0;
              bus.out_count <= 2'd0;
              state         <= IDLE;
            end else begin
              bus.out_inst <= enc_addiu(rd_q, low_q);
              bus.out_last <= 1'b1;
              state        <= EMIT_ADDIU;
            end
          end
        end
        EMIT_ADDIU: begin
          if (bus.out_ready) begin
            bus.in_ready  <= 1'b1;
            bus.out_valid <= 1'b0;
            bus.out_inst  <= 16'h0000;
            bus.out_last  <= 1'b0;
            bus.out_count <= 2'd0;
            state         <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_const_encoder.sv
// Directed testbench for const_encoder. Two instances are driven: one with
// ALLOW_SHORT=1 (dut_s) and one with ALLOW_SHORT=0 (dut_l). The "sel" variable
// picks which instance receives the request and whose outputs are observed.
module tb_const_encoder;

  logic        clk;
  logic        rst;
  logic        sel;
  logic        in_valid;
  logic [15:0] in_value;
  logic [2:0]  in_rd;
  logic        out_ready;

  logic        obs_in_ready;
  logic        obs_out_valid;
  logic [15:0] obs_out_inst;
  logic        obs_out_last;
  logic [1:0]  obs_out_count;

  int n_cmp;
  int n_fail;

  const_encoder_if bus_s ();
  const_encoder_if bus_l ();

  const_encoder #(.ALLOW_SHORT(1'b1)) dut_s (.clk(clk), .rst(rst), .bus(bus_s.slave));
  const_encoder #(.ALLOW_SHORT(1'b0)) dut_l (.clk(clk), .rst(rst), .bus(bus_l.slave));

  assign bus_s.in_valid  = in_valid & ~sel;
  assign bus_l.in_valid  = in_valid & sel;
  assign bus_s.in_value  = in_value;
  assign bus_l.in_value  = in_value;
  assign bus_s.in_rd     = in_rd;
  assign bus_l.in_rd     = in_rd;
  assign bus_s.out_ready = out_ready;
  assign bus_l.out_ready = out_ready;

  assign obs_in_ready  = sel ? bus_l.in_ready  : bus_s.in_ready;
  assign obs_out_valid = sel ? bus_l.out_valid : bus_s.out_valid;
  assign obs_out_inst  = sel ? bus_l.out_inst  : bus_s.out_inst;
  assign obs_out_last  = sel ? bus_l.out_last  : bus_s.out_last;
  assign obs_out_count = sel ? bus_l.out_count : bus_s.out_count;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] observed, input logic [15:0] expected);
    n_cmp++;
    assert (observed === expected)
    else begin
      n_fail++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // Issues one request on the selected instance; returns on the negedge after
  // the capture edge, where the first beat should already be visible.
  task automatic applyStimulus(input logic which, input logic [15:0] value, input logic [2:0] rd);
    int waited;
    sel    = which;
    waited = 0;
    while (!obs_in_ready && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    chk("in_ready_wait", {15'd0, obs_in_ready}, 16'd1);
    in_value = value;
    in_rd    = rd;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Waits (bounded) for a valid beat, checks it, and lets out_ready consume it.
  task automatic checkOutput(input string tag, input logic [15:0] exp_inst,
                             input logic exp_last, input logic [1:0] exp_count);
    int waited;
    waited = 0;
    while (!obs_out_valid && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    chk({tag, "_valid"}, {15'd0, obs_out_valid}, 16'd1);
    chk({tag, "_inst"},  obs_out_inst, exp_inst);
    chk({tag, "_last"},  {15'd0, obs_out_last}, {15'd0, exp_last});
    chk({tag, "_count"}, {14'd0, obs_out_count}, {14'd0, exp_count});
    chk({tag, "_in_ready"}, {15'd0, obs_in_ready}, 16'd0);
    @(negedge clk);
  endtask

  initial begin
    n_cmp     = 0;
    n_fail    = 0;
    sel       = 1'b0;
    in_valid  = 1'b0;
    in_value  = 16'h0000;
    in_rd     = 3'd0;
    out_ready = 1'b1;
    rst       = 1'b1;
    #12;

    // Reset state of both instances
    for (int k = 0; k < 2; k++) begin
      sel = k[0];
      #1;
      chk("rst_out_valid", {15'd0, obs_out_valid}, 16'd0);
      chk("rst_out_inst",  obs_out_inst, 16'h0000);
      chk("rst_out_last",  {15'd0, obs_out_last}, 16'd0);
      chk("rst_out_count", {14'd0, obs_out_count}, 16'd0);
      chk("rst_in_ready",  {15'd0, obs_in_ready}, 16'd1);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Test 1: H==0 -> single LI, latency 1
    applyStimulus(1'b0, 16'h0042, 3'd3);
    chk("t1_latency", {15'd0, obs_out_valid}, 16'd1);
    checkOutput("t1_li", 16'h6B42, 1'b1, 2'd1);
    chk("t1_done", {15'd0, obs_out_valid}, 16'd0);
    chk("t1_idle_ready", {15'd0, obs_in_ready}, 16'd1);

    // Test 2: L==0 -> LI ; SLL
    applyStimulus(1'b0, 16'h1200, 3'd1);
    checkOutput("t2_li",  16'h6912, 1'b0, 2'd2);
    checkOutput("t2_sll", 16'h3120, 1'b1, 2'd2);
    chk("t2_done", {15'd0, obs_out_valid}, 16'd0);

    // Test 3: full form, Hadj=0x13 because L[7]=1
    applyStimulus(1'b0, 16'h12F0, 3'd2);
    checkOutput("t3_li",    16'h6A13, 1'b0, 2'd3);
    checkOutput("t3_sll",   16'h3240, 1'b0, 2'd3);
    checkOutput("t3_addiu", 16'h4AF0, 1'b1, 2'd3);

    // Test 4: Hadj wraps 0xFF+1 -> 0x00
    applyStimulus(1'b0, 16'hFF80, 3'd0);
    checkOutput("t4_li",    16'h6800, 1'b0, 2'd3);
    checkOutput("t4_sll",   16'h3000, 1'b0, 2'd3);
    checkOutput("t4_addiu", 16'h4880, 1'b1, 2'd3);

    // Zero value takes the single-LI form
    applyStimulus(1'b0, 16'h0000, 3'd5);
    checkOutput("t4z_li", 16'h6D00, 1'b1, 2'd1);

    // Test 1 repeated with ALLOW_SHORT=0
    applyStimulus(1'b1, 16'h0042, 3'd3);
    checkOutput("t4l_li",    16'h6B00, 1'b0, 2'd3);
    checkOutput("t4l_sll",   16'h3360, 1'b0, 2'd3);
    checkOutput("t4l_addiu", 16'h4B42, 1'b1, 2'd3);

    // Test 5: backpressure on the SLL beat for 3 cycles
    applyStimulus(1'b0, 16'h12F0, 3'd2);
    checkOutput("t5_li", 16'h6A13, 1'b0, 2'd3);
    out_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      chk("t5_hold_inst",  obs_out_inst, 16'h3240);
      chk("t5_hold_valid", {15'd0, obs_out_valid}, 16'd1);
      chk("t5_hold_last",  {15'd0, obs_out_last}, 16'd0);
      chk("t5_hold_ready", {15'd0, obs_in_ready}, 16'd0);
      @(negedge clk);
    end
    out_ready = 1'b1;
    checkOutput("t5_sll",   16'h3240, 1'b0, 2'd3);
    checkOutput("t5_addiu", 16'h4AF0, 1'b1, 2'd3);

    // Test 6: reset pulsed while the SLL beat is showing
    applyStimulus(1'b0, 16'h12F0, 3'd2);
    checkOutput("t6_li", 16'h6A13, 1'b0, 2'd3);
    chk("t6_pre_inst", obs_out_inst, 16'h3240);
    rst = 1'b1;
    #1;
    chk("t6_rst_valid",    {15'd0, obs_out_valid}, 16'd0);
    chk("t6_rst_in_ready", {15'd0, obs_in_ready}, 16'd1);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    applyStimulus(1'b0, 16'h0042, 3'd3);
    checkOutput("t6_li_after", 16'h6B42, 1'b1, 2'd1);
    chk("t6_done", {15'd0, obs_out_valid}, 16'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
